// File: rtl/debug_linearizer_mp_if.sv
// Handshake bundle between the debug module, the execution pipes and the debug pipeline linearizer.
// The master side drives the requests and busy flags; the slave side is the linearizer.
interface debug_linearizer_mp_if #(
  parameter int NUM_PIPES = 4
);
  logic                 debug_on;
  logic                 flush_flag;
  logic [NUM_PIPES-1:0] ex_busy;
  logic                 multi_pipe;
  logic                 step_req;
  logic                 empty_core;
  logic                 line_stall;
  logic                 line_clr;
  logic                 step_grant;
  logic                 drain_done;
  logic                 drain_timeout;
  logic [1:0]           lin_state;

  modport master (
    output debug_on, flush_flag, ex_busy, multi_pipe, step_req,
    input  empty_core, line_stall, line_clr, step_grant, drain_done, drain_timeout, lin_state
  );

  modport slave (
    input  debug_on, flush_flag, ex_busy, multi_pipe, step_req,
    output empty_core, line_stall, line_clr, step_grant, drain_done, drain_timeout, lin_state
  );
endinterface

// File: rtl/debug_linearizer_mp.sv
// Debug-mode pipeline linearizer: drains the execution pipes on a debug flush, stalls issue while halted
// and supports single-step issue. Optional drain watchdog enabled by defining LIN_TIMEOUT_EN.
module debug_linearizer_mp #(
  parameter int NUM_PIPES  = 4,
  parameter int MIN_DRAIN  = 2,
  parameter int TMO_CYCLES = 256
) (
  input logic                     clk,
  input logic                     rst,
  debug_linearizer_mp_if.slave    lin
);

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    DEBUG      = 2'd1,
    CHECK_PIPE = 2'd2,
    STEP       = 2'd3
  } linState_e;

  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] MinLast = CW'(MIN_DRAIN - 1);
  localparam logic [CW-1:0] CntMax  = CW'(TMO_CYCLES);
`ifdef LIN_TIMEOUT_EN
  localparam logic [CW-1:0] TmoLast = CW'(TMO_CYCLES - 1);
`endif

  linState_e            state_q, state_d;
  logic [CW-1:0]        drainCnt_q, drainCnt_d;
  logic                 drainDone_q, drainDone_d;
  logic                 drainTmo_q, drainTmo_d;
  logic [NUM_PIPES-1:0] busyVec;
  logic                 anyBusy;
  logic                 drained;
  logic                 timeoutHit;
  logic                 haltedView;

  assign busyVec = lin.ex_busy;
  assign anyBusy = |busyVec;

  always_comb begin
    state_d     = state_q;
    drainCnt_d  = '0;
    drainDone_d = 1'b0;
    drainTmo_d  = drainTmo_q;
    drained     = (drainCnt_q >= MinLast) && !anyBusy;
`ifdef LIN_TIMEOUT_EN
    timeoutHit  = anyBusy && (drainCnt_q == TmoLast);
`else
    timeoutHit  = 1'b0;
`endif

    unique case (state_q)
      NORMAL: begin
        if (lin.flush_flag)    state_d = CHECK_PIPE;
        else if (lin.debug_on) state_d = DEBUG;
      end
      DEBUG: begin
        if (lin.flush_flag)                state_d = CHECK_PIPE;
        else if (!lin.debug_on)            state_d = NORMAL;
        else if (lin.step_req && !anyBusy) state_d = STEP;
      end
      STEP: state_d = CHECK_PIPE;
      CHECK_PIPE: begin
        // flush_flag is deliberately ignored here so a level flush cannot restart the dwell
        if (drained || timeoutHit) state_d = lin.debug_on ? DEBUG : NORMAL;
      end
      default: state_d = NORMAL;
    endcase

    if (state_q == CHECK_PIPE && state_d == CHECK_PIPE) begin
      drainCnt_d = (drainCnt_q == CntMax) ? drainCnt_q : drainCnt_q + 1'b1;
    end
    drainDone_d = (state_q == CHECK_PIPE) && (state_d != CHECK_PIPE);

    // Watchdog flag survives the exit and is only wiped by the next drain or by reset
    if (state_q != CHECK_PIPE && state_d == CHECK_PIPE) begin
      drainTmo_d = 1'b0;
    end else if (state_q == CHECK_PIPE && timeoutHit) begin
      drainTmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NORMAL;
      drainCnt_q  <= '0;
      drainDone_q <= 1'b0;
      drainTmo_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drainCnt_q  <= drainCnt_d;
      drainDone_q <= drainDone_d;
      drainTmo_q  <= drainTmo_d;
    end
  end

  assign haltedView        = (state_q == DEBUG) || (state_q == CHECK_PIPE);
  assign lin.empty_core    = !anyBusy;
  assign lin.line_stall    = (anyBusy || lin.multi_pipe) && haltedView;
  assign lin.line_clr      = lin.multi_pipe && haltedView;
  assign lin.step_grant    = (state_q == STEP);
  assign lin.drain_done    = drainDone_q;
  assign lin.drain_timeout = drainTmo_q;
  assign lin.lin_state     = state_q;

endmodule

// File: tb/tb_debug_linearizer_mp.sv
// Self-checking bench for debug_linearizer_mp: directed scenarios followed by random traffic,
// every output compared each cycle against a cycle-level behavioural model of the linearizer.
module tb_debug_linearizer_mp;
  localparam int NumPipes  = 4;
  localparam int MinDrain  = 2;
  localparam int TmoCycles = 16;

  logic clk = 1'b0;
  logic rst;

  debug_linearizer_mp_if #(.NUM_PIPES(NumPipes)) linIf();

  debug_linearizer_mp #(
    .NUM_PIPES (NumPipes),
    .MIN_DRAIN (MinDrain),
    .TMO_CYCLES(TmoCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lin(linIf)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;
  int checkSeen  = 0;

  // Model: mode 0 running, 1 halted, 2 draining, 3 stepping; mCycles = cycles spent draining so far
  int   mState  = 0;
  int   mCycles = 0;
  logic mDone   = 1'b0;
  logic mTmo    = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic busy, halted;
    busy   = |linIf.ex_busy;
    halted = (mState == 1) || (mState == 2);
    checkVal({tag, ".lin_state"},     32'(linIf.lin_state),     32'(mState));
    checkVal({tag, ".empty_core"},    32'(linIf.empty_core),    32'(!busy));
    checkVal({tag, ".line_stall"},    32'(linIf.line_stall),    32'((busy || linIf.multi_pipe) && halted));
    checkVal({tag, ".line_clr"},      32'(linIf.line_clr),      32'(linIf.multi_pipe && halted));
    checkVal({tag, ".step_grant"},    32'(linIf.step_grant),    32'(mState == 3));
    checkVal({tag, ".drain_done"},    32'(linIf.drain_done),    32'(mDone));
    checkVal({tag, ".drain_timeout"}, 32'(linIf.drain_timeout), 32'(mTmo));
    if (linIf.lin_state == 2'd2) checkSeen++;
  endtask

  task automatic applyStimulus(input logic dbg, input logic flush, input logic [NumPipes-1:0] busyIn,
                               input logic multi, input logic step, input string tag);
    int   nState, nCycles;
    logic busy, leaveNow, dogFired;
    linIf.debug_on   = dbg;
    linIf.flush_flag = flush;
    linIf.ex_busy    = busyIn;
    linIf.multi_pipe = multi;
    linIf.step_req   = step;
    #3;
    checkOutput(tag);
    busy     = |busyIn;
    dogFired = 1'b0;
    nState   = mState;
    case (mState)
      0: nState = flush ? 2 : (dbg ? 1 : 0);
      1: nState = flush ? 2 : (!dbg ? 0 : ((step && !busy) ? 3 : 1));
      3: nState = 2;
      default: begin
        leaveNow = (mCycles + 1 >= MinDrain) && !busy;
`ifdef LIN_TIMEOUT_EN
        if (busy && mCycles + 1 == TmoCycles) begin
          leaveNow = 1'b1;
          dogFired = 1'b1;
        end
`endif
        nState = leaveNow ? (dbg ? 1 : 0) : 2;
      end
    endcase
    nCycles = (mState == 2 && nState == 2) ? ((mCycles < TmoCycles) ? mCycles + 1 : mCycles) : 0;
    @(posedge clk);
    mDone = (mState == 2) && (nState != 2);
    if (mState != 2 && nState == 2) mTmo = 1'b0;
    else if (dogFired) mTmo = 1'b1;
    mState  = nState;
    mCycles = nCycles;
    #1;
  endtask

  task automatic modelReset();
    mState  = 0;
    mCycles = 0;
    mDone   = 1'b0;
    mTmo    = 1'b0;
  endtask

  initial begin
    logic       rDbg;
    logic [3:0] rBusy;
    rst              = 1'b0;
    linIf.debug_on   = 1'b0;
    linIf.flush_flag = 1'b0;
    linIf.ex_busy    = '0;
    linIf.multi_pipe = 1'b0;
    linIf.step_req   = 1'b0;
    #12;
    checkOutput("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Flush from halt with pipe 1 busy for five cycles: six cycles of drain, then done pulse
    applyStimulus(1, 0, 4'b0000, 0, 0, "t1.enter");
    checkSeen = 0;
    applyStimulus(1, 1, 4'b0000, 0, 0, "t1.flush");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 4'b0010, 0, 0, "t1.busy");
    applyStimulus(1, 0, 4'b0000, 0, 0, "t1.clear");
    applyStimulus(1, 0, 4'b0000, 0, 0, "t1.done");
    checkVal("t1.drainCycles", 32'(checkSeen), 32'd6);

    // Idle pipes: drain lasts exactly the minimum dwell, then back to running
    checkSeen = 0;
    applyStimulus(0, 1, 4'b0000, 0, 0, "t2.flush");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 4'b0000, 0, 0, "t2.idle");
    checkVal("t2.drainCycles", 32'(checkSeen), 32'(MinDrain));

    // Single step, then drain of the stepped instruction on pipe 2
    applyStimulus(1, 0, 4'b0000, 0, 0, "t3.halt");
    applyStimulus(1, 0, 4'b0000, 0, 1, "t3.req");
    applyStimulus(1, 0, 4'b0000, 0, 0, "t3.grant");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 4'b0100, 0, 0, "t3.busy");
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 4'b0000, 0, 0, "t3.back");

    // Multi-cycle instruction at issue while halted, then resume
    applyStimulus(1, 0, 4'b0000, 1, 0, "t4.clr");
    applyStimulus(0, 0, 4'b0000, 1, 0, "t4.resume");
    applyStimulus(0, 0, 4'b0000, 1, 0, "t4.normal");

    // Pipe 3 stuck busy: watchdog exit when enabled, otherwise an indefinite drain
    applyStimulus(0, 1, 4'b0000, 0, 0, "t5.flush");
    for (int i = 0; i < 120; i++) applyStimulus(0, 0, 4'b1000, 0, 0, "t5.stuck");
`ifdef LIN_TIMEOUT_EN
    checkVal("t5.watchdogFlag", 32'(linIf.drain_timeout), 32'd1);
`else
    checkVal("t5.stillDraining", 32'(linIf.lin_state), 32'd2);
`endif
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'b0000, 0, 0, "t5.release");

    // Asynchronous reset in the middle of a drain
    applyStimulus(1, 1, 4'b0000, 0, 0, "t6.flush");
    applyStimulus(1, 0, 4'b0001, 0, 0, "t6.drain");
    rst = 1'b0;
    #2;
    modelReset();
    checkOutput("t6.asyncReset");
    @(posedge clk);
    #1;
    checkOutput("t6.held");
    rst = 1'b1;
    applyStimulus(0, 0, 4'b0000, 0, 0, "t6.after");

    // Random traffic with slowly toggling debug_on and sparse busy pipes
    rDbg = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rDbg = ~rDbg;
      rBusy = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      applyStimulus(rDbg, ($urandom_range(0, 11) == 0), rBusy, ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0), "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
